// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   8N1 UART receiver clocked entirely on sysclk. Rising edges of the 16x
//   oversample clock become one-cycle sample ticks. Each bit is decided by a
//   3-sample majority vote around mid-bit. Completed bytes go to a 1-entry
//   valid/ready output buffer.
// Ports
//   sysclk      in   system clock, all logic on posedge
//   reset       in   asynchronous active-high reset
//   sysclk_sam  in   oversample clock (OVERSAMPLE ticks per bit), sysclk-derived
//   uart_rx     in   serial line, idle high, asynchronous
//   rx_data     out  received byte, valid while rx_valid=1
//   rx_valid    out  buffer holds an unread byte
//   rx_ready    in   consumer accepts; transfer on rx_valid & rx_ready
//   frame_err   out  one-cycle pulse when the stop bit votes low
//   overrun     out  sticky: a completed byte was dropped on a full buffer
module uart_rx_sampler #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sysclk_sam,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned SAMP_A = OVERSAMPLE / 2 - 1;
  localparam int unsigned SAMP_B = OVERSAMPLE / 2;
  localparam int unsigned SAMP_C = OVERSAMPLE / 2 + 1;
  localparam int unsigned LAST   = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state, w_state_n;
  logic                   r_sam_prev;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n;
  logic [BIT_W-1:0]       r_bitn, w_bitn_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic [1:0]             r_samp, w_samp_n;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_tick;
  logic w_rx_s;
  logic w_vote;
  logic w_commit;
  logic w_ferr;
  logic w_xfer;
  logic w_drop;

  assign w_tick = sysclk_sam & ~r_sam_prev;
  assign w_rx_s = r_sync[SYNC_STAGES-1];
  // Majority of the two stored mid-bit samples and the current one.
  assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);

  // Edge detector and line synchronizer.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_sam_prev <= 1'b0;
      r_sync     <= '1;
    end else begin
      r_sam_prev <= sysclk_sam;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], uart_rx};
    end
  end

  // Receive FSM state register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_samp  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bitn  <= w_bitn_n;
      r_shift <= w_shift_n;
      r_samp  <= w_samp_n;
    end
  end

  // Receive FSM next state; everything advances on sample ticks only.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bitn_n  = r_bitn;
    w_shift_n = r_shift;
    w_samp_n  = r_samp;
    w_commit  = 1'b0;
    w_ferr    = 1'b0;
    if (w_tick) begin
      w_cnt_n = (r_cnt == CNT_W'(LAST)) ? '0 : r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(SAMP_A)) w_samp_n[0] = w_rx_s;
      if (r_cnt == CNT_W'(SAMP_B)) w_samp_n[1] = w_rx_s;
      case (r_state)
        S_IDLE: begin
          w_cnt_n = '0;
          if (!w_rx_s) w_state_n = S_START;
        end
        S_START: begin
          if (r_cnt == CNT_W'(SAMP_C) && w_vote) begin
            // Start bit did not hold through mid-bit: treat as a glitch.
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
          end else if (r_cnt == CNT_W'(LAST)) begin
            w_state_n = S_DATA;
            w_bitn_n  = '0;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_W'(SAMP_C)) w_shift_n = {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_cnt == CNT_W'(LAST)) begin
            if (r_bitn == BIT_W'(DATA_BITS - 1)) w_state_n = S_STOP;
            else                                 w_bitn_n  = r_bitn + BIT_W'(1);
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (r_cnt == CNT_W'(SAMP_C)) begin
            w_cnt_n = '0;
            if (w_vote) begin
              w_commit  = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_ferr    = 1'b1;
              w_state_n = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          w_cnt_n = '0;
          if (w_rx_s) w_state_n = S_IDLE;
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  assign w_xfer = r_rx_valid & rx_ready;
  assign w_drop = w_commit & r_rx_valid & ~rx_ready;

  // Output buffer, handshake and status flags.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_commit && !w_drop) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rx_valid <= 1'b0;
      end
      if (w_drop)      r_overrun <= 1'b1;
      else if (w_xfer) r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
